// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARMv4 banked register file:
//   - processor mode encodings (CPSR[4:0])
//   - bank index enum used for R13/R14 and SPSR selection
//   - layout constants of the flat physical register array
//   - mode_to_bank / mode_is_legal helpers
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  // SYS shares the USR bank, so it has no index of its own.
  typedef enum logic [2:0] {
    BK_USR = 3'd0,
    BK_FIQ = 3'd1,
    BK_IRQ = 3'd2,
    BK_SVC = 3'd3,
    BK_ABT = 3'd4,
    BK_UND = 3'd5
  } bank_e;

  localparam int NUM_BANKS = 6;

  // Physical layout: 0..7 R0-R7, 8..12 R8-R12 (user copy),
  // 13..17 R8-R12 (FIQ copy), 18+2*bank R13, 19+2*bank R14.
  localparam int         NUM_PHYS      = 30;
  localparam logic [4:0] PHYS_FIQ_BASE = 5'd13;
  localparam logic [4:0] PHYS_R13_BASE = 5'd18;

  // Illegal encodings fall back to the USR bank.
  function automatic bank_e mode_to_bank(input logic [4:0] m);
    bank_e b;
    case (m)
      MODE_FIQ: b = BK_FIQ;
      MODE_IRQ: b = BK_IRQ;
      MODE_SVC: b = BK_SVC;
      MODE_ABT: b = BK_ABT;
      MODE_UND: b = BK_UND;
      MODE_USR: b = BK_USR;
      MODE_SYS: b = BK_USR;
      default:  b = BK_USR;
    endcase
    return b;
  endfunction

  function automatic logic mode_is_legal(input logic [4:0] m);
    logic ok;
    case (m)
      MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
      MODE_ABT, MODE_UND, MODE_SYS: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/arm_bank_map.sv
// ---------------------------------------------------------------------------
// arm_bank_map
// Combinational map from an architectural register address to an index in
// the flat physical register array.
//   m_i          current mode (CPSR[4:0])
//   user_bank_i  force the USR/SYS view
//   addr_i       architectural register number 0..15
//   phys_idx_o   physical index (don't care when is_pc_o=1)
//   is_pc_o      address 15, served by the PC register
// ---------------------------------------------------------------------------
module arm_bank_map
  import arm_pkg::*;
(
  input  logic [4:0] m_i,
  input  logic       user_bank_i,
  input  logic [3:0] addr_i,
  output logic [4:0] phys_idx_o,
  output logic       is_pc_o
);

  bank_e bank_s;

  assign bank_s = user_bank_i ? BK_USR : mode_to_bank(m_i);

  // Address decode into shared, FIQ-banked and per-mode R13/R14 regions.
  always_comb begin
    phys_idx_o = 5'd0;
    is_pc_o    = 1'b0;
    if (addr_i == 4'd15) begin
      is_pc_o = 1'b1;
    end else if (addr_i >= 4'd13) begin
      // R13 has addr[0]=1 (offset 0), R14 has addr[0]=0 (offset 1).
      phys_idx_o = PHYS_R13_BASE + {1'b0, bank_s, 1'b0} + {4'd0, ~addr_i[0]};
    end else if ((addr_i >= 4'd8) && (bank_s == BK_FIQ)) begin
      phys_idx_o = PHYS_FIQ_BASE + {2'b00, addr_i[2:0]};
    end else begin
      phys_idx_o = {1'b0, addr_i};
    end
  end

endmodule

// File: rtl/arm_banked_regfile_mp.sv
// ---------------------------------------------------------------------------
// arm_banked_regfile_mp
// ARMv4 banked register file with NUM_RD read ports, two write ports,
// optional write-to-read bypass, PC auto-increment and per-mode SPSRs.
//   clk, Rst             clock / async active-high reset
//   M, User_Bank         mode and forced user view for R0-R14
//   R_Addr / R_Data      packed read ports (combinational)
//   Write_Reg0/1, W_*    write ports (port 1 wins on collision)
//   Write_PC, PC_New,
//   PC_Inc, PC           PC control and registered PC
//   Write_SPSR, SPSR_In,
//   SPSR_Out             SPSR of the mode selected by M
//   Mode_Err             M is not a legal mode
// ---------------------------------------------------------------------------
module arm_banked_regfile_mp
  import arm_pkg::*;
#(
  parameter int DW      = 32,
  parameter int NUM_RD  = 3,
  parameter int BYPASS  = 1,
  parameter int PC_STEP = 4
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic [4:0]           M,
  input  logic                 User_Bank,
  input  logic [4*NUM_RD-1:0]  R_Addr,
  output logic [DW*NUM_RD-1:0] R_Data,
  input  logic                 Write_Reg0,
  input  logic [3:0]           W_Addr0,
  input  logic [DW-1:0]        W_Data0,
  input  logic                 Write_Reg1,
  input  logic [3:0]           W_Addr1,
  input  logic [DW-1:0]        W_Data1,
  input  logic                 Write_PC,
  input  logic [DW-1:0]        PC_New,
  input  logic                 PC_Inc,
  output logic [DW-1:0]        PC,
  input  logic                 Write_SPSR,
  input  logic [DW-1:0]        SPSR_In,
  output logic [DW-1:0]        SPSR_Out,
  output logic                 Mode_Err
);

  logic [DW-1:0] regs_q [NUM_PHYS];
  logic [DW-1:0] regs_d [NUM_PHYS];
  logic [DW-1:0] spsr_q [NUM_BANKS];
  logic [DW-1:0] spsr_d [NUM_BANKS];
  logic [DW-1:0] pc_q, pc_d;

  logic [4:0]        w0_idx_s, w1_idx_s;
  logic              w0_pc_s, w1_pc_s;
  logic              w0_gpr_s, w1_gpr_s;
  logic [4:0]        rd_idx_s [NUM_RD];
  logic [NUM_RD-1:0] rd_pc_s;
  logic              byp_en_s;
  bank_e             spsr_bank_s;

  arm_bank_map u_map_w0 (
    .m_i(M), .user_bank_i(User_Bank), .addr_i(W_Addr0),
    .phys_idx_o(w0_idx_s), .is_pc_o(w0_pc_s)
  );

  arm_bank_map u_map_w1 (
    .m_i(M), .user_bank_i(User_Bank), .addr_i(W_Addr1),
    .phys_idx_o(w1_idx_s), .is_pc_o(w1_pc_s)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_map
    arm_bank_map u_map_rd (
      .m_i(M), .user_bank_i(User_Bank), .addr_i(R_Addr[4*g +: 4]),
      .phys_idx_o(rd_idx_s[g]), .is_pc_o(rd_pc_s[g])
    );
  end

  assign w0_gpr_s = Write_Reg0 & ~w0_pc_s;
  assign w1_gpr_s = Write_Reg1 & ~w1_pc_s;
  // Reset overrides pending writes, so bypass is suppressed while it is held.
  assign byp_en_s = (BYPASS != 0) & ~Rst;

  // SPSR selection ignores User_Bank.
  assign spsr_bank_s = mode_to_bank(M);
  assign Mode_Err    = ~mode_is_legal(M);
  assign PC          = pc_q;
  assign SPSR_Out    = (spsr_bank_s == BK_USR) ? '0 : spsr_q[spsr_bank_s];

  // GPR next state: port 1 beats port 0 on the same physical register.
  always_comb begin
    for (int i = 0; i < NUM_PHYS; i++) begin
      if (w1_gpr_s && (w1_idx_s == 5'(i))) begin
        regs_d[i] = W_Data1;
      end else if (w0_gpr_s && (w0_idx_s == 5'(i))) begin
        regs_d[i] = W_Data0;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // SPSR next state; USR/SYS have no SPSR so the write is dropped there.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (Write_SPSR && (spsr_bank_s != BK_USR) && (spsr_bank_s == 3'(i))) begin
        spsr_d[i] = SPSR_In;
      end else begin
        spsr_d[i] = spsr_q[i];
      end
    end
  end

  // PC next state in priority order; the add wraps modulo 2^DW.
  always_comb begin
    if (Write_PC) begin
      pc_d = PC_New;
    end else if (Write_Reg1 && w1_pc_s) begin
      pc_d = W_Data1;
    end else if (Write_Reg0 && w0_pc_s) begin
      pc_d = W_Data0;
    end else if (PC_Inc) begin
      pc_d = pc_q + DW'(PC_STEP);
    end else begin
      pc_d = pc_q;
    end
  end

  // Read ports, optionally bypassing the winning same-cycle write.
  always_comb begin
    R_Data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_pc_s[i]) begin
        R_Data[DW*i +: DW] = pc_q;
      end else if (byp_en_s && w1_gpr_s && (w1_idx_s == rd_idx_s[i])) begin
        R_Data[DW*i +: DW] = W_Data1;
      end else if (byp_en_s && w0_gpr_s && (w0_idx_s == rd_idx_s[i])) begin
        R_Data[DW*i +: DW] = W_Data0;
      end else begin
        R_Data[DW*i +: DW] = regs_q[rd_idx_s[i]];
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        regs_q[i] <= '0;
      end
      for (int i = 0; i < NUM_BANKS; i++) begin
        spsr_q[i] <= '0;
      end
      pc_q <= '0;
    end else begin
      regs_q <= regs_d;
      spsr_q <= spsr_d;
      pc_q   <= pc_d;
    end
  end

endmodule

// File: tb/tb_arm_banked_regfile_mp.sv
module tb_arm_banked_regfile_mp;

  localparam logic [4:0] U   = 5'b10000;
  localparam logic [4:0] F   = 5'b10001;
  localparam logic [4:0] I   = 5'b10010;
  localparam logic [4:0] S   = 5'b10011;
  localparam logic [4:0] A   = 5'b10111;
  localparam logic [4:0] UN  = 5'b11011;
  localparam logic [4:0] SY  = 5'b11111;
  localparam logic [4:0] BAD = 5'b11010;

  logic         clk;
  logic         Rst;
  logic [4:0]   M;
  logic         User_Bank;
  logic [11:0]  R_Addr;
  logic [95:0]  R_Data;
  logic         Write_Reg0, Write_Reg1, Write_PC, PC_Inc, Write_SPSR;
  logic [3:0]   W_Addr0, W_Addr1;
  logic [31:0]  W_Data0, W_Data1, PC_New, PC, SPSR_In, SPSR_Out;
  logic         Mode_Err;

  int checks;
  int errors;

  typedef struct {
    logic [4:0]  m;
    logic        ub;
    logic        we0;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        wpc;
    logic [31:0] pcn;
    logic        inc;
    logic        wsp;
    logic [31:0] spi;
    logic [3:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2, epc, esp;
    logic        eerr;
  } vec_t;

  vec_t tv [$];

  arm_banked_regfile_mp #(.DW(32), .NUM_RD(3), .BYPASS(1), .PC_STEP(4)) dut (
    .clk(clk), .Rst(Rst), .M(M), .User_Bank(User_Bank),
    .R_Addr(R_Addr), .R_Data(R_Data),
    .Write_Reg0(Write_Reg0), .W_Addr0(W_Addr0), .W_Data0(W_Data0),
    .Write_Reg1(Write_Reg1), .W_Addr1(W_Addr1), .W_Data1(W_Data1),
    .Write_PC(Write_PC), .PC_New(PC_New), .PC_Inc(PC_Inc), .PC(PC),
    .Write_SPSR(Write_SPSR), .SPSR_In(SPSR_In), .SPSR_Out(SPSR_Out),
    .Mode_Err(Mode_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    User_Bank = 1'b0;
    Write_Reg0 = 1'b0; W_Addr0 = 4'd0; W_Data0 = 32'd0;
    Write_Reg1 = 1'b0; W_Addr1 = 4'd0; W_Data1 = 32'd0;
    Write_PC = 1'b0; PC_New = 32'd0; PC_Inc = 1'b0;
    Write_SPSR = 1'b0; SPSR_In = 32'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // {m,ub, we0,wa0,wd0, we1,wa1,wd1, wpc,pcn,inc, wsp,spi, ra0,ra1,ra2, e0,e1,e2, epc,esp,eerr}
    // Bank isolation
    tv.push_back('{U,0, 1,2,32'hFFFFFFFF, 1,11,32'hAAAAAAAA, 0,0,0, 0,0, 2,11,13, 32'hFFFFFFFF,32'hAAAAAAAA,0, 0,0,0});
    tv.push_back('{U,0, 1,13,32'h40404040, 0,0,0, 0,0,0, 0,0, 2,11,13, 32'hFFFFFFFF,32'hAAAAAAAA,32'h40404040, 0,0,0});
    tv.push_back('{F,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 2,11,13, 32'hFFFFFFFF,0,0, 0,0,0});
    tv.push_back('{U,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 2,11,13, 32'hFFFFFFFF,32'hAAAAAAAA,32'h40404040, 0,0,0});
    // Dual write collision, port 1 wins and is bypassed
    tv.push_back('{F,0, 1,9,32'h3F3F3F3F, 1,9,32'hF3F3F3F3, 0,0,0, 0,0, 9,9,8, 32'hF3F3F3F3,32'hF3F3F3F3,0, 0,0,0});
    tv.push_back('{F,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 9,11,15, 32'hF3F3F3F3,0,0, 0,0,0});
    tv.push_back('{U,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 9,2,13, 0,32'hFFFFFFFF,32'h40404040, 0,0,0});
    // Forced user view
    tv.push_back('{UN,1, 1,14,32'h81818181, 0,0,0, 0,0,0, 0,0, 14,13,2, 32'h81818181,32'h40404040,32'hFFFFFFFF, 0,0,0});
    tv.push_back('{UN,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 14,13,2, 0,0,32'hFFFFFFFF, 0,0,0});
    tv.push_back('{SY,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 14,13,11, 32'h81818181,32'h40404040,32'hAAAAAAAA, 0,0,0});
    // PC wrap and priority
    tv.push_back('{U,0, 0,0,0, 0,0,0, 1,32'hFFFFFFFC,0, 0,0, 15,15,0, 0,0,0, 0,0,0});
    tv.push_back('{U,0, 0,0,0, 0,0,0, 0,0,1, 0,0, 15,0,0, 32'hFFFFFFFC,0,0, 32'hFFFFFFFC,0,0});
    tv.push_back('{U,0, 1,15,32'h8, 0,0,0, 1,32'h87654321,1, 0,0, 15,0,0, 0,0,0, 0,0,0});
    tv.push_back('{U,0, 1,15,32'h200, 1,15,32'h100, 0,0,1, 0,0, 15,0,0, 32'h87654321,0,0, 32'h87654321,0,0});
    tv.push_back('{U,0, 1,15,32'h200, 0,0,0, 0,0,1, 0,0, 15,0,0, 32'h100,0,0, 32'h100,0,0});
    tv.push_back('{U,0, 0,0,0, 0,0,0, 0,0,1, 0,0, 15,0,0, 32'h200,0,0, 32'h200,0,0});
    tv.push_back('{U,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 15,2,0, 32'h204,32'hFFFFFFFF,0, 32'h204,0,0});
    // SPSR
    tv.push_back('{S,0, 0,0,0, 0,0,0, 0,0,0, 1,32'h600000D3, 13,14,15, 0,0,32'h204, 32'h204,0,0});
    tv.push_back('{S,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 13,14,15, 0,0,32'h204, 32'h204,32'h600000D3,0});
    tv.push_back('{I,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 32'h204,0,0});
    tv.push_back('{U,0, 0,0,0, 0,0,0, 0,0,0, 1,32'h12345678, 0,0,0, 0,0,0, 32'h204,0,0});
    tv.push_back('{SY,0, 0,0,0, 0,0,0, 0,0,0, 1,32'h11111111, 0,0,0, 0,0,0, 32'h204,0,0});
    tv.push_back('{S,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 32'h204,32'h600000D3,0});
    tv.push_back('{A,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 32'h204,0,0});
    // Illegal mode behaves as USR
    tv.push_back('{BAD,0, 1,10,32'h0A0A0A0A, 0,0,0, 0,0,0, 1,32'h55555555, 13,14,10, 32'h40404040,32'h81818181,32'h0A0A0A0A, 32'h204,0,1});
    tv.push_back('{U,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 10,12,0, 32'h0A0A0A0A,0,0, 32'h204,0,0});
    tv.push_back('{F,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 10,13,14, 0,0,0, 32'h204,0,0});

    // Reset state
    Rst = 1'b1;
    M = U;
    idle();
    R_Addr = {4'd15, 4'd13, 4'd2};
    #3;
    chk("reset_r2", R_Data[31:0], 32'd0);
    chk("reset_r13", R_Data[63:32], 32'd0);
    chk("reset_r15", R_Data[95:64], 32'd0);
    chk("reset_pc", PC, 32'd0);
    chk("reset_spsr", SPSR_Out, 32'd0);
    @(negedge clk);
    Rst = 1'b0;

    for (int k = 0; k < tv.size(); k++) begin
      M = tv[k].m; User_Bank = tv[k].ub;
      Write_Reg0 = tv[k].we0; W_Addr0 = tv[k].wa0; W_Data0 = tv[k].wd0;
      Write_Reg1 = tv[k].we1; W_Addr1 = tv[k].wa1; W_Data1 = tv[k].wd1;
      Write_PC = tv[k].wpc; PC_New = tv[k].pcn; PC_Inc = tv[k].inc;
      Write_SPSR = tv[k].wsp; SPSR_In = tv[k].spi;
      R_Addr = {tv[k].ra2, tv[k].ra1, tv[k].ra0};
      #2;
      chk($sformatf("v%0d_rd0", k), R_Data[31:0], tv[k].e0);
      chk($sformatf("v%0d_rd1", k), R_Data[63:32], tv[k].e1);
      chk($sformatf("v%0d_rd2", k), R_Data[95:64], tv[k].e2);
      chk($sformatf("v%0d_pc", k), PC, tv[k].epc);
      chk($sformatf("v%0d_spsr", k), SPSR_Out, tv[k].esp);
      chk($sformatf("v%0d_moderr", k), {31'd0, Mode_Err}, {31'd0, tv[k].eerr});
      @(negedge clk);
    end

    // Asynchronous reset between edges with a write pending
    idle();
    M = S;
    Write_Reg0 = 1'b1; W_Addr0 = 4'd2; W_Data0 = 32'h00000005;
    R_Addr = {4'd15, 4'd11, 4'd2};
    #2;
    Rst = 1'b1;
    #1;
    chk("arst_r2", R_Data[31:0], 32'd0);
    chk("arst_r11", R_Data[63:32], 32'd0);
    chk("arst_r15", R_Data[95:64], 32'd0);
    chk("arst_pc", PC, 32'd0);
    chk("arst_spsr", SPSR_Out, 32'd0);
    #1;
    Rst = 1'b0;
    @(negedge clk);
    Write_Reg0 = 1'b0;
    M = U;
    #1;
    chk("resume_r2", R_Data[31:0], 32'h00000005);
    chk("resume_r11", R_Data[63:32], 32'd0);
    chk("resume_pc", PC, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
